// File: rtl/instr_controller_if.sv
// Strobe/handshake bundle between instr_controller and the datapath.
// The controller owns the master modport; the datapath (or a bench) takes the slave side.
interface instr_controller_if #(
  parameter int unsigned WIDTH = 16
);
  logic             s;
  logic [WIDTH-1:0] in;
  logic             w;
  logic             err;
  logic [2:0]       readnum;
  logic [2:0]       writenum;
  logic [1:0]       vsel;
  logic             loada;
  logic             loadb;
  logic             loadc;
  logic             loads;
  logic             write;
  logic             asel;
  logic             bsel;
  logic [1:0]       shift;
  logic [1:0]       ALUop;
  logic [WIDTH-1:0] sximm5;
  logic [WIDTH-1:0] sximm8;

  modport master (
    input  s, in,
    output w, err, readnum, writenum, vsel,
    output loada, loadb, loadc, loads, write,
    output asel, bsel, shift, ALUop, sximm5, sximm8
  );

  modport slave (
    output s, in,
    input  w, err, readnum, writenum, vsel,
    input  loada, loadb, loadc, loads, write,
    input  asel, bsel, shift, ALUop, sximm5, sximm8
  );
endinterface

// File: rtl/instr_controller.sv
// Instruction decoder and sequencing FSM for the RISC core.
// Latches an instruction on the start handshake, then walks the datapath through
// read / ALU / write-back phases one strobe per cycle and returns to WAIT.
// Build option: define CTRL_ILLEGAL_HALT_EN to make illegal instructions halt the
// controller with err=1 (left only by reset); otherwise they retire as a NOP.
module instr_controller #(
  parameter int unsigned WIDTH = 16
) (
  input logic                clk,
  input logic                reset_n,
  instr_controller_if.master bus
);

  typedef enum logic [2:0] {
    StWait   = 3'd0,
    StDecode = 3'd1,
    StGetA   = 3'd2,
    StGetB   = 3'd3,
    StAlu    = 3'd4,
    StWrImm  = 3'd5,
    StWrReg  = 3'd6,
    StHalt   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;

  // Instruction fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  // Instruction classes
  logic is_mov_imm;
  logic is_mov_reg;
  logic is_alu;
  logic is_cmp;
  logic is_mvn;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);

  // Immediates track IR continuously
  assign bus.sximm5 = {{(WIDTH - 5){ir_q[4]}}, ir_q[4:0]};
  assign bus.sximm8 = {{(WIDTH - 8){ir_q[7]}}, ir_q[7:0]};

  // State and instruction register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWait;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR loads only on an accepted start, so it is stable for the whole instruction
  always_comb begin
    ir_d = ir_q;
    if ((state_q == StWait) && bus.s) begin
      ir_d = bus.in;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait: begin
        if (bus.s) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_mov_imm) begin
          state_d = StWrImm;
        end else if (is_mov_reg || is_mvn) begin
          state_d = StGetB;
        end else if (is_alu) begin
          state_d = StGetA;
        end else begin
`ifdef CTRL_ILLEGAL_HALT_EN
          state_d = StHalt;
`else
          state_d = StWait;
`endif
        end
      end
      StGetA:  state_d = StGetB;
      StGetB:  state_d = StAlu;
      StAlu:   state_d = is_cmp ? StWait : StWrReg;
      StWrImm: state_d = StWait;
      StWrReg: state_d = StWait;
      StHalt: begin
`ifdef CTRL_ILLEGAL_HALT_EN
        state_d = StHalt;
`else
        state_d = StWait;
`endif
      end
      default: state_d = StWait;
    endcase
  end

  // Moore outputs decoded from state and IR
  always_comb begin
    bus.w        = (state_q == StWait);
    bus.err      = 1'b0;
    bus.readnum  = 3'b000;
    bus.writenum = 3'b000;
    bus.vsel     = 2'b11;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.write    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.shift    = 2'b00;
    bus.ALUop    = 2'b00;
    unique case (state_q)
      StGetA: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
      end
      StGetB: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      StAlu: begin
        bus.shift = sh;
        // MOV reg is computed as 0 + shifted Rm
        bus.ALUop = is_mov_reg ? 2'b00 : op;
        bus.asel  = is_mov_reg;
        bus.loadc = !is_cmp;
        bus.loads = is_cmp;
      end
      StWrImm: begin
        bus.writenum = rn;
        bus.vsel     = 2'b01;
        bus.write    = 1'b1;
      end
      StWrReg: begin
        bus.writenum = rd;
        bus.vsel     = 2'b11;
        bus.write    = 1'b1;
      end
      StHalt: begin
`ifdef CTRL_ILLEGAL_HALT_EN
        bus.err = 1'b1;
`endif
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_instr_controller.sv
// Directed self-checking bench for instr_controller.
// Honors CTRL_ILLEGAL_HALT_EN the same way as the design.
module tb_instr_controller;

  logic clk;
  logic reset_n;

  instr_controller_if #(.WIDTH(16)) bus ();

  instr_controller #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        loada, loadb, loadc, loads, write, asel, bsel, err;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, aluop;
    logic [15:0] sximm5, sximm8;
  } snap_t;

  localparam int MaxCyc = 20;

  int    n_cmp = 0;
  int    n_mis = 0;
  snap_t tr [0:MaxCyc-1];
  int    ncyc;
  int    cnt_loada, cnt_loadb, cnt_loadc, cnt_loads, cnt_write;

  function automatic snap_t snap();
    snap_t t;
    t.loada    = bus.loada;
    t.loadb    = bus.loadb;
    t.loadc    = bus.loadc;
    t.loads    = bus.loads;
    t.write    = bus.write;
    t.asel     = bus.asel;
    t.bsel     = bus.bsel;
    t.err      = bus.err;
    t.readnum  = bus.readnum;
    t.writenum = bus.writenum;
    t.vsel     = bus.vsel;
    t.shift    = bus.shift;
    t.aluop    = bus.ALUop;
    t.sximm5   = bus.sximm5;
    t.sximm8   = bus.sximm8;
    return t;
  endfunction

  // Pulse s for one cycle from WAIT, then record every cycle while w is low.
  // `in` is scrambled after acceptance so an IR that follows `in` shows up.
  task automatic run_instr(input logic [15:0] instr);
    bus.s  = 1'b1;
    bus.in = instr;
    @(posedge clk); #1;
    bus.s  = 1'b0;
    bus.in = 16'h5A5A;
    ncyc = 0;
    cnt_loada = 0; cnt_loadb = 0; cnt_loadc = 0; cnt_loads = 0; cnt_write = 0;
    while (bus.w === 1'b0 && ncyc < MaxCyc) begin
      tr[ncyc] = snap();
      cnt_loada += int'(bus.loada);
      cnt_loadb += int'(bus.loadb);
      cnt_loadc += int'(bus.loadc);
      cnt_loads += int'(bus.loads);
      cnt_write += int'(bus.write);
      ncyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.s   = 1'b0;
    bus.in  = 16'hFFFF;
    #12;
    n_cmp++;
    if (bus.w !== 1'b1 || bus.err !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_w_err got w=%b err=%b want w=1 err=0", bus.w, bus.err);
    end
    n_cmp++;
    if ({bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write, bus.asel, bus.bsel} !== 7'b0) begin
      n_mis++;
      $display("FAIL reset_strobes got %b want 0000000", {bus.loada, bus.loadb, bus.loadc,
               bus.loads, bus.write, bus.asel, bus.bsel});
    end
    n_cmp++;
    if ({bus.readnum, bus.writenum, bus.vsel, bus.shift, bus.ALUop} !== 12'b000_000_11_00_00) begin
      n_mis++;
      $display("FAIL reset_selects got %b want 000000110000",
               {bus.readnum, bus.writenum, bus.vsel, bus.shift, bus.ALUop});
    end
    n_cmp++;
    if (bus.sximm5 !== 16'h0000 || bus.sximm8 !== 16'h0000) begin
      n_mis++;
      $display("FAIL reset_imm got %h/%h want 0000/0000", bus.sximm5, bus.sximm8);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mov_imm();
    // MOV R2,#5
    run_instr(16'hD205);
    n_cmp++;
    if (ncyc !== 2) begin
      n_mis++; $display("FAIL movimm_low got %0d want 2", ncyc);
    end
    n_cmp++;
    if (tr[0].write !== 1'b0 || tr[1].write !== 1'b1 || tr[1].writenum !== 3'd2 ||
        tr[1].vsel !== 2'b01 || tr[1].sximm8 !== 16'h0005) begin
      n_mis++;
      $display("FAIL movimm_wr got write=%b%b wn=%0d vsel=%b imm8=%h want 01/2/01/0005",
               tr[0].write, tr[1].write, tr[1].writenum, tr[1].vsel, tr[1].sximm8);
    end
    n_cmp++;
    if (cnt_write !== 1 || cnt_loada + cnt_loadb + cnt_loadc + cnt_loads !== 0) begin
      n_mis++;
      $display("FAIL movimm_strobes got write=%0d others=%0d want 1/0", cnt_write,
               cnt_loada + cnt_loadb + cnt_loadc + cnt_loads);
    end
    // MOV R0,#-1: both immediates sign-extend to all ones
    run_instr(16'hD0FF);
    n_cmp++;
    if (ncyc !== 2 || tr[1].writenum !== 3'd0 || tr[1].sximm8 !== 16'hFFFF ||
        tr[1].sximm5 !== 16'hFFFF) begin
      n_mis++;
      $display("FAIL movimm_neg got low=%0d wn=%0d imm8=%h imm5=%h want 2/0/FFFF/FFFF",
               ncyc, tr[1].writenum, tr[1].sximm8, tr[1].sximm5);
    end
  endtask

  task automatic test_add();
    // ADD R7,R0,R1 LSL: Rn=0 Rd=7 sh=01 Rm=1
    run_instr(16'hA0E9);
    n_cmp++;
    if (ncyc !== 5) begin
      n_mis++; $display("FAIL add_low got %0d want 5", ncyc);
    end
    n_cmp++;
    if (tr[1].loada !== 1'b1 || tr[1].readnum !== 3'd0 || tr[2].loadb !== 1'b1 ||
        tr[2].readnum !== 3'd1) begin
      n_mis++;
      $display("FAIL add_read got A=%b/%0d B=%b/%0d want 1/0 1/1",
               tr[1].loada, tr[1].readnum, tr[2].loadb, tr[2].readnum);
    end
    n_cmp++;
    if (tr[3].loadc !== 1'b1 || tr[3].loads !== 1'b0 || tr[3].shift !== 2'b01 ||
        tr[3].aluop !== 2'b00 || tr[3].asel !== 1'b0 || tr[3].bsel !== 1'b0) begin
      n_mis++;
      $display("FAIL add_alu got c=%b s=%b sh=%b op=%b asel=%b bsel=%b want 1 0 01 00 0 0",
               tr[3].loadc, tr[3].loads, tr[3].shift, tr[3].aluop, tr[3].asel, tr[3].bsel);
    end
    n_cmp++;
    if (tr[4].write !== 1'b1 || tr[4].writenum !== 3'd7 || tr[4].vsel !== 2'b11) begin
      n_mis++;
      $display("FAIL add_wr got write=%b wn=%0d vsel=%b want 1/7/11",
               tr[4].write, tr[4].writenum, tr[4].vsel);
    end
    n_cmp++;
    if ({cnt_loada, cnt_loadb, cnt_loadc, cnt_loads, cnt_write} !== {32'd1, 32'd1, 32'd1,
        32'd0, 32'd1}) begin
      n_mis++;
      $display("FAIL add_counts got a=%0d b=%0d c=%0d s=%0d w=%0d want 1 1 1 0 1",
               cnt_loada, cnt_loadb, cnt_loadc, cnt_loads, cnt_write);
    end
    // AND R6,R2,R3: 5 cycles, ALUop=10
    run_instr(16'hB2C3);
    n_cmp++;
    if (ncyc !== 5 || tr[3].aluop !== 2'b10 || tr[4].writenum !== 3'd6) begin
      n_mis++;
      $display("FAIL and_seq got low=%0d op=%b wn=%0d want 5/10/6",
               ncyc, tr[3].aluop, tr[4].writenum);
    end
  endtask

  task automatic test_cmp();
    // CMP R1,R2
    run_instr(16'hA902);
    n_cmp++;
    if (ncyc !== 4) begin
      n_mis++; $display("FAIL cmp_low got %0d want 4", ncyc);
    end
    n_cmp++;
    if (tr[3].loads !== 1'b1 || tr[3].aluop !== 2'b01 || tr[1].readnum !== 3'd1 ||
        tr[2].readnum !== 3'd2) begin
      n_mis++;
      $display("FAIL cmp_alu got s=%b op=%b rnA=%0d rnB=%0d want 1/01/1/2",
               tr[3].loads, tr[3].aluop, tr[1].readnum, tr[2].readnum);
    end
    n_cmp++;
    if (cnt_loadc !== 0 || cnt_write !== 0 || cnt_loads !== 1) begin
      n_mis++;
      $display("FAIL cmp_counts got c=%0d w=%0d s=%0d want 0/0/1", cnt_loadc, cnt_write, cnt_loads);
    end
  endtask

  task automatic test_mov_reg();
    // MOV R3,R3: IR[4:3] of 16'hC06B is 2'b01
    run_instr(16'hC06B);
    n_cmp++;
    if (ncyc !== 4 || cnt_loada !== 0) begin
      n_mis++; $display("FAIL movreg_seq got low=%0d loada=%0d want 4/0", ncyc, cnt_loada);
    end
    n_cmp++;
    if (tr[1].loadb !== 1'b1 || tr[1].readnum !== 3'd3 || tr[2].asel !== 1'b1 ||
        tr[2].aluop !== 2'b00 || tr[2].shift !== 2'b01 || tr[2].loadc !== 1'b1) begin
      n_mis++;
      $display("FAIL movreg_alu got b=%b rn=%0d asel=%b op=%b sh=%b c=%b want 1 3 1 00 01 1",
               tr[1].loadb, tr[1].readnum, tr[2].asel, tr[2].aluop, tr[2].shift, tr[2].loadc);
    end
    n_cmp++;
    if (tr[3].write !== 1'b1 || tr[3].writenum !== 3'd3 || tr[3].vsel !== 2'b11) begin
      n_mis++;
      $display("FAIL movreg_wr got w=%b wn=%0d vsel=%b want 1/3/11",
               tr[3].write, tr[3].writenum, tr[3].vsel);
    end
    // MVN R4,R5: skips GET_A, ALUop=11, asel=0
    run_instr(16'hB885);
    n_cmp++;
    if (ncyc !== 4 || cnt_loada !== 0 || tr[2].aluop !== 2'b11 || tr[2].asel !== 1'b0 ||
        tr[3].writenum !== 3'd4 || tr[1].readnum !== 3'd5) begin
      n_mis++;
      $display("FAIL mvn_seq got low=%0d a=%0d op=%b asel=%b wn=%0d rn=%0d want 4 0 11 0 4 5",
               ncyc, cnt_loada, tr[2].aluop, tr[2].asel, tr[3].writenum, tr[1].readnum);
    end
  endtask

  task automatic test_back_to_back();
    int lowc;
    int nloads;
    int nwrite;
    bus.s  = 1'b1;
    bus.in = 16'hD205;
    @(posedge clk); #1;
    bus.in = 16'hA902;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.write !== 1'b1 || bus.writenum !== 3'd2) begin
      n_mis++;
      $display("FAIL b2b_ir_stable got w=%b wn=%0d want 1/2", bus.write, bus.writenum);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.w !== 1'b1) begin
      n_mis++; $display("FAIL b2b_retire got w=%b want 1", bus.w);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.w !== 1'b0) begin
      n_mis++; $display("FAIL b2b_nobubble got w=%b want 0", bus.w);
    end
    bus.s  = 1'b0;
    bus.in = 16'h0000;
    lowc   = 1;
    nloads = 0;
    nwrite = 0;
    while (lowc < MaxCyc) begin
      @(posedge clk); #1;
      if (bus.w === 1'b1) break;
      lowc++;
      nloads += int'(bus.loads);
      nwrite += int'(bus.write);
    end
    n_cmp++;
    if (lowc !== 4 || nloads !== 1 || nwrite !== 0) begin
      n_mis++;
      $display("FAIL b2b_cmp got low=%0d loads=%0d write=%0d want 4/1/0", lowc, nloads, nwrite);
    end
  endtask

  task automatic test_reset_mid();
    int nwrite;
    bus.s  = 1'b1;
    bus.in = 16'hA0E9;
    @(posedge clk); #1;
    bus.s = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.loadb !== 1'b1) begin
      n_mis++; $display("FAIL rstmid_getb got loadb=%b want 1", bus.loadb);
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.w !== 1'b1 || bus.loadb !== 1'b0 || bus.sximm8 !== 16'h0000) begin
      n_mis++;
      $display("FAIL rstmid_abort got w=%b loadb=%b imm8=%h want 1/0/0000",
               bus.w, bus.loadb, bus.sximm8);
    end
    @(negedge clk);
    reset_n = 1'b1;
    nwrite = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      nwrite += int'(bus.write);
    end
    n_cmp++;
    if (nwrite !== 0 || bus.w !== 1'b1) begin
      n_mis++; $display("FAIL rstmid_nowrite got write=%0d w=%b want 0/1", nwrite, bus.w);
    end
  endtask

  task automatic test_illegal();
`ifdef CTRL_ILLEGAL_HALT_EN
    int nwrite;
    bus.s  = 1'b1;
    bus.in = 16'hE000;
    @(posedge clk); #1;
    bus.s = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.err !== 1'b1 || bus.w !== 1'b0) begin
      n_mis++; $display("FAIL halt_enter got err=%b w=%b want 1/0", bus.err, bus.w);
    end
    nwrite = 0;
    for (int i = 0; i < 3; i++) begin
      bus.s  = 1'b1;
      bus.in = 16'hD205;
      @(posedge clk); #1;
      bus.s = 1'b0;
      @(posedge clk); #1;
      nwrite += int'(bus.write | bus.loada | bus.loadb | bus.loadc | bus.loads);
    end
    n_cmp++;
    if (bus.err !== 1'b1 || bus.w !== 1'b0 || nwrite !== 0) begin
      n_mis++;
      $display("FAIL halt_sticky got err=%b w=%b strobes=%0d want 1/0/0", bus.err, bus.w, nwrite);
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.err !== 1'b0 || bus.w !== 1'b1) begin
      n_mis++; $display("FAIL halt_reset got err=%b w=%b want 0/1", bus.err, bus.w);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
`else
    run_instr(16'hE000);
    n_cmp++;
    if (ncyc !== 1) begin
      n_mis++; $display("FAIL nop_low got %0d want 1", ncyc);
    end
    n_cmp++;
    if (cnt_loada + cnt_loadb + cnt_loadc + cnt_loads + cnt_write !== 0 || tr[0].err !== 1'b0 ||
        bus.err !== 1'b0) begin
      n_mis++;
      $display("FAIL nop_quiet got strobes=%0d err=%b want 0/0",
               cnt_loada + cnt_loadb + cnt_loadc + cnt_loads + cnt_write, tr[0].err);
    end
`endif
    // Controller still works after the illegal instruction
    run_instr(16'hD205);
    n_cmp++;
    if (ncyc !== 2 || cnt_write !== 1) begin
      n_mis++; $display("FAIL illegal_recover got low=%0d write=%0d want 2/1", ncyc, cnt_write);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mov_reg();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Absolute time bound in case the sequencing wedges somewhere unforeseen
  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
